// File: rtl/fpu_result_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_result_buf
//  Purpose  : Output-side sink for the FPU. Captures every result beat
//             (result / fflags / iflags / error / user) into a small FIFO and
//             re-presents the oldest entry downstream on a valid/ready
//             handshake. Produces the FPU stall back-pressure early enough
//             that beats still in flight in the FPU pipeline always fit.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   clock
//    rst            in   asynchronous reset, active-low (0 = reset)
//    fpu_valid_i    in   FPU beat valid (no ready on this side)
//    fpu_result_i   in   FPU result          [RS_W]
//    fpu_fflags_i   in   FP exception flags  [FF_W]
//    fpu_iflags_i   in   integer flags       [IF_W]
//    fpu_error_i    in   error               [ERR_W]
//    fpu_user_i     in   user sideband       [USR_W]
//    stall_o        out  back-pressure to the FPU stall input
//    out_valid_o    out  head entry valid
//    out_ready_i    in   consumer accepts head
//    out_*_o        out  head entry fields
//    count_o        out  occupancy          [$clog2(DEPTH)+1]
//    overflow_o     out  sticky: a beat arrived while full and was dropped
// ============================================================================
module fpu_result_buf #(
  parameter int RS_W  = 32,
  parameter int FF_W  = 5,
  parameter int IF_W  = 4,
  parameter int ERR_W = 1,
  parameter int USR_W = 8,
  parameter int DEPTH = 4,
  parameter int SKID  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fpu_valid_i,
  input  logic [RS_W-1:0]          fpu_result_i,
  input  logic [FF_W-1:0]          fpu_fflags_i,
  input  logic [IF_W-1:0]          fpu_iflags_i,
  input  logic [ERR_W-1:0]         fpu_error_i,
  input  logic [USR_W-1:0]         fpu_user_i,
  output logic                     stall_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [RS_W-1:0]          out_result_o,
  output logic [FF_W-1:0]          out_fflags_o,
  output logic [IF_W-1:0]          out_iflags_o,
  output logic [ERR_W-1:0]         out_error_o,
  output logic [USR_W-1:0]         out_user_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = RS_W + FF_W + IF_W + ERR_W + USR_W;

  localparam logic [CW-1:0] c_depth     = CW'(DEPTH);
  localparam logic [CW-1:0] c_stall_thr = CW'(DEPTH - SKID);
  localparam logic [PW-1:0] c_ptr_one   = PW'(1);

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic          r_stall;
  logic          r_overflow;

  logic          w_full;
  logic          w_pop;
  logic          w_push_acc;
  logic          w_drop;
  logic [CW-1:0] w_count_next;
  logic [EW-1:0] w_wr_data;

  assign w_full     = (r_count == c_depth);
  assign w_pop      = r_out_valid & out_ready_i;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign w_push_acc = fpu_valid_i & (~w_full | w_pop);
  assign w_drop     = fpu_valid_i & w_full & ~w_pop;

  assign w_count_next = r_count + CW'(w_push_acc) - CW'(w_pop);

  assign w_wr_data = {fpu_result_i, fpu_fflags_i, fpu_iflags_i, fpu_error_i, fpu_user_i};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_stall     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_mem[r_wr_ptr] <= w_wr_data;
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      r_count     <= w_count_next;
      r_out_valid <= (w_count_next != '0);
      // Raised once occupancy leaves only SKID free slots, so the beats the
      // FPU emits before it sees the stall always find room.
      r_stall     <= (w_count_next >= c_stall_thr);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Head entry is read straight from storage; only registered state feeds it.
  assign {out_result_o, out_fflags_o, out_iflags_o, out_error_o, out_user_o} = r_mem[r_rd_ptr];

  assign out_valid_o = r_out_valid;
  assign stall_o     = r_stall;
  assign count_o     = r_count;
  assign overflow_o  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_result_buf
//  Purpose  : Self-checking bench for fpu_result_buf (DEPTH=4, SKID=2).
//             Cycle table for single-beat, fill/stall, full push+pop,
//             drop/overflow and drain; hand sequences for flow-controlled
//             wrap and asynchronous reset mid-drain.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_result_buf;

  logic        clk;
  logic        rst;
  logic        fpu_valid_i;
  logic [31:0] fpu_result_i;
  logic [4:0]  fpu_fflags_i;
  logic [3:0]  fpu_iflags_i;
  logic [0:0]  fpu_error_i;
  logic [7:0]  fpu_user_i;
  logic        stall_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_result_o;
  logic [4:0]  out_fflags_o;
  logic [3:0]  out_iflags_o;
  logic [0:0]  out_error_o;
  logic [7:0]  out_user_o;
  logic [2:0]  count_o;
  logic        overflow_o;

  int n_chk;
  int n_fail;

  fpu_result_buf dut (
    .clk          (clk),
    .rst          (rst),
    .fpu_valid_i  (fpu_valid_i),
    .fpu_result_i (fpu_result_i),
    .fpu_fflags_i (fpu_fflags_i),
    .fpu_iflags_i (fpu_iflags_i),
    .fpu_error_i  (fpu_error_i),
    .fpu_user_i   (fpu_user_i),
    .stall_o      (stall_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_result_o (out_result_o),
    .out_fflags_o (out_fflags_o),
    .out_iflags_o (out_iflags_o),
    .out_error_o  (out_error_o),
    .out_user_o   (out_user_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat id -> field values. Id 0 is the single-beat example value.
  function automatic logic [31:0] b_res(input int id);
    return (id == 0) ? 32'h3F80_0000 : (32'hB000_0000 | 32'(id));
  endfunction
  function automatic logic [4:0] b_ff(input int id);
    return (id == 0) ? 5'h01 : 5'(id + 2);
  endfunction
  function automatic logic [7:0] b_usr(input int id);
    return (id == 0) ? 8'hA5 : 8'(8'h50 + id);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit push, input int id, input bit rdy);
    logic [31:0] r;
    r            = b_res(id);
    fpu_valid_i  = push;
    fpu_result_i = r;
    fpu_fflags_i = b_ff(id);
    fpu_iflags_i = r[3:0];
    fpu_error_i  = r[4];
    fpu_user_i   = b_usr(id);
    out_ready_i  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string pfx, input int id);
    logic [31:0] r;
    r = b_res(id);
    chk({pfx, " result"}, 64'(out_result_o), 64'(r));
    chk({pfx, " fflags"}, 64'(out_fflags_o), 64'(b_ff(id)));
    chk({pfx, " iflags"}, 64'(out_iflags_o), 64'(r[3:0]));
    chk({pfx, " error"},  64'(out_error_o),  64'(r[4]));
    chk({pfx, " user"},   64'(out_user_o),   64'(b_usr(id)));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  typedef struct {
    bit push;
    int pid;
    bit rdy;
    bit ev;
    int eid;
    int ecnt;
    bit est;
    bit eov;
  } row_t;

  row_t tbl[32];
  int   n_rows;

  task automatic add(input bit p, input int pid, input bit r, input bit ev,
                     input int eid, input int c, input bit s, input bit o);
    tbl[n_rows] = '{p, pid, r, ev, eid, c, s, o};
    n_rows++;
  endtask

  int q[$];
  int sent;
  int got;
  int exp_id;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    n_rows = 0;

    // push pid rdy | ev eid cnt stall ovf   (expected after the edge)
    add(1, 0, 1,  1, 0, 1, 0, 0);   // single beat, visible next cycle
    add(0, 0, 1,  0, 0, 0, 0, 0);   // popped, empty again
    add(1, 1, 0,  1, 1, 1, 0, 0);   // fill with ready low
    add(1, 2, 0,  1, 1, 2, 1, 0);   // stall after 2nd push
    add(1, 3, 0,  1, 1, 3, 1, 0);
    add(1, 4, 0,  1, 1, 4, 1, 0);   // full, no overflow
    add(1, 5, 1,  1, 2, 4, 1, 0);   // full push+pop: count holds
    add(0, 0, 1,  1, 3, 3, 1, 0);
    add(0, 0, 1,  1, 4, 2, 1, 0);
    add(0, 0, 1,  1, 5, 1, 0, 0);   // beat 5 comes out last
    add(0, 0, 1,  0, 0, 0, 0, 0);
    add(1, 6, 0,  1, 6, 1, 0, 0);   // refill
    add(1, 7, 0,  1, 6, 2, 1, 0);
    add(1, 8, 0,  1, 6, 3, 1, 0);
    add(1, 9, 0,  1, 6, 4, 1, 0);
    add(1, 10, 0, 1, 6, 4, 1, 1);   // dropped beat, overflow set
    add(0, 0, 0,  1, 6, 4, 1, 1);   // sticky, head unchanged
    add(0, 0, 1,  1, 7, 3, 1, 1);
    add(0, 0, 1,  1, 8, 2, 1, 1);
    add(0, 0, 1,  1, 9, 1, 0, 1);
    add(0, 0, 1,  0, 0, 0, 0, 1);   // beat 10 never appears

    // ---------------- reset state ----------------
    do_reset();
    chk("reset valid",    64'(out_valid_o),  64'd0);
    chk("reset count",    64'(count_o),      64'd0);
    chk("reset stall",    64'(stall_o),      64'd0);
    chk("reset overflow", 64'(overflow_o),   64'd0);
    chk("reset result",   64'(out_result_o), 64'd0);

    // ---------------- table ----------------
    for (int r = 0; r < n_rows; r++) begin
      drive(tbl[r].push, tbl[r].pid, tbl[r].rdy);
      tick();
      chk($sformatf("row%0d valid", r),    64'(out_valid_o), 64'(tbl[r].ev));
      chk($sformatf("row%0d count", r),    64'(count_o),     64'(tbl[r].ecnt));
      chk($sformatf("row%0d stall", r),    64'(stall_o),     64'(tbl[r].est));
      chk($sformatf("row%0d overflow", r), 64'(overflow_o),  64'(tbl[r].eov));
      if (tbl[r].ev) chk_head($sformatf("row%0d head", r), tbl[r].eid);
    end

    // ---------------- flow-controlled stream with pointer wrap ----------------
    do_reset();
    q.delete();
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      bit rdy;
      bit psh;
      rdy = (cyc % 2 == 0);
      psh = !stall_o && (sent < 10);
      drive(psh, 20 + sent, rdy);
      if (out_valid_o && rdy) begin
        exp_id = q.pop_front();
        chk($sformatf("stream beat%0d", got), 64'(out_result_o), 64'(b_res(exp_id)));
        got++;
      end
      if (psh) begin
        q.push_back(20 + sent);
        sent++;
      end
      tick();
      chk($sformatf("stream c%0d count", cyc), 64'(count_o), 64'(q.size()));
      chk($sformatf("stream c%0d stall", cyc), 64'(stall_o), 64'(q.size() >= 2));
    end
    chk("stream received", 64'(got), 64'd10);
    chk("stream overflow", 64'(overflow_o), 64'd0);

    // ---------------- asynchronous reset mid-drain ----------------
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 30 + k, 1'b0);
      tick();
    end
    drive(1'b0, 0, 1'b1);
    tick();
    chk("pre-rst count",    64'(count_o),    64'd3);
    chk("pre-rst overflow", 64'(overflow_o), 64'd1);
    chk_head("pre-rst head", 31);
    #3;
    rst = 1'b0;
    #1;
    chk("async rst valid",    64'(out_valid_o), 64'd0);
    chk("async rst stall",    64'(stall_o),     64'd0);
    chk("async rst count",    64'(count_o),     64'd0);
    chk("async rst overflow", 64'(overflow_o),  64'd0);
    drive(1'b0, 0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("post-rst valid", 64'(out_valid_o), 64'd0);
    chk("post-rst count", 64'(count_o),     64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
